// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and the
// long-operation classifier.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_XOR   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_AND   = 4'b0100,
        OP_SLT   = 4'b0101,
        OP_SLTU  = 4'b0110,
        OP_SLL   = 4'b0111,
        OP_SRL   = 4'b1000,
        OP_SRA   = 4'b1001,
        OP_MUL   = 4'b1010,
        OP_MULHU = 4'b1011,
        OP_DIVU  = 4'b1100,
        OP_REMU  = 4'b1101,
        OP_RSV0  = 4'b1110,
        OP_RSV1  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic is_long_op(input alu_op_e op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the operand stage (master) and
// the sequential ALU (slave).
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    alu_op_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier / restoring divider, one bit per cycle.
// The hi/lo pair is the product accumulator for MUL and remainder/quotient for DIV.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hi_q, lo_q, b_q;
    logic             div_q;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] hi_n, lo_n;

    // With b == 0 every compare succeeds, so the quotient fills with ones and
    // the remainder ends up equal to a without any special casing.
    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        ge      = (shifted >= {1'b0, b_q});
        diff    = shifted[WIDTH-1:0] - b_q;
        if (div_q) begin
            hi_n = ge ? diff : shifted[WIDTH-1:0];
            lo_n = {lo_q[WIDTH-2:0], ge};
        end else begin
            hi_n = add_sum[WIDTH:1];
            lo_n = {add_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (abort) begin
            count <= '0;
        end else if (start) begin
            count <= CW'(WIDTH);
            hi_q  <= '0;
            lo_q  <= a;
            b_q   <= b;
            div_q <= is_div;
        end else if (count != '0) begin
            count <= count - 1'b1;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
        end
    end

    // Results are the post-step values so the caller can capture them on the final step.
    assign done       = (count == CW'(1));
    assign product_lo = lo_n;
    assign product_hi = hi_n;
    assign quotient   = lo_n;
    assign remainder  = hi_n;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle simple ops, WIDTH-cycle mul/div,
// with a registered result held until the consumer takes it.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    alu_seq_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);

    alu_state_e       state, next_state;
    alu_op_e          op_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] simple_res;
    logic [WIDTH-1:0] long_res;
    logic [SW-1:0]    shamt;

    logic in_ready, out_valid, accept, start_long, load_simple, load_long;
    logic iter_done;
    logic [WIDTH-1:0] product_lo, product_hi, quotient, remainder;

    assign shamt = bus.b[SW-1:0];

    always_comb begin
        simple_res = '0;
        case (bus.op)
            OP_ADD:  simple_res = bus.a + bus.b;
            OP_SUB:  simple_res = bus.a - bus.b;
            OP_XOR:  simple_res = bus.a ^ bus.b;
            OP_OR:   simple_res = bus.a | bus.b;
            OP_AND:  simple_res = bus.a & bus.b;
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SLL:  simple_res = bus.a << shamt;
            OP_SRL:  simple_res = bus.a >> shamt;
            OP_SRA:  simple_res = $signed(bus.a) >>> shamt;
            default: simple_res = '0;
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .reset      (reset),
        .start      (start_long),
        .abort      (flush),
        .is_div     ((bus.op == OP_DIVU) || (bus.op == OP_REMU)),
        .a          (bus.a),
        .b          (bus.b),
        .done       (iter_done),
        .product_lo (product_lo),
        .product_hi (product_hi),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    always_comb begin
        case (op_q)
            OP_MUL:   long_res = product_lo;
            OP_MULHU: long_res = product_hi;
            OP_DIVU:  long_res = quotient;
            default:  long_res = remainder;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // flush wins over everything, including a handshake in the same cycle.
    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept) next_state = is_long_op(bus.op) ? ST_BUSY : ST_DONE;
                ST_BUSY: if (iter_done) next_state = ST_DONE;
                ST_DONE: begin
                    if (accept)             next_state = is_long_op(bus.op) ? ST_BUSY : ST_DONE;
                    else if (bus.out_ready) next_state = ST_IDLE;
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready    = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
        out_valid   = (state == ST_DONE);
        accept      = bus.in_valid && in_ready && !flush;
        start_long  = accept && is_long_op(bus.op);
        load_simple = accept && !is_long_op(bus.op);
        load_long   = (state == ST_BUSY) && iter_done && !flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            op_q     <= OP_ADD;
        end else begin
            if (start_long)       op_q     <= bus.op;
            if (load_simple)      result_q <= simple_res;
            else if (load_long)   result_q <= long_res;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32 with hand-computed
// results, latencies, backpressure, flush and reset-abort scenarios.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   testCount = 0;
    int   failCount = 0;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Present one op, then scramble the operand inputs once accepted; returns
    // the number of edges until out_valid (bounded).
    task automatic applyStimulus(input alu_op_e o, input logic [31:0] x, input logic [31:0] y, output int lat);
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        lat          = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            bus.in_valid = 1'b0;
            bus.op       = OP_SUB;
            bus.a        = 32'hFFFF_FFFF;
            bus.b        = 32'h5A5A_5A5A;
        end while (!bus.out_valid && lat < 100);
    endtask

    task automatic runCheck(input string tag, input alu_op_e o, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] expRes, input int expLat);
        int lat;
        applyStimulus(o, x, y, lat);
        checkOutput($sformatf("%s_result", tag), bus.result, expRes);
        checkOutput($sformatf("%s_zero", tag), {31'b0, bus.zero}, {31'b0, (expRes == 32'h0)});
        checkOutput($sformatf("%s_latency", tag), lat, expLat);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        bus.in_valid  = 1'b0;
        bus.op        = OP_ADD;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        flush         = 1'b0;
        reset         = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("rst_result", bus.result, 32'd0);
        checkOutput("rst_zero", {31'b0, bus.zero}, 32'd1);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Simple ops, back-to-back with out_ready held high
        runCheck("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         1);
        runCheck("sub",      OP_SUB,  32'h3,         32'h5,         32'hFFFF_FFFE, 1);
        runCheck("slt",      OP_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1);
        runCheck("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1);
        runCheck("sra",      OP_SRA,  32'h8000_0000, 32'h24,        32'hF800_0000, 1);
        runCheck("srl",      OP_SRL,  32'h8000_0000, 32'h4,         32'h0800_0000, 1);
        runCheck("sll",      OP_SLL,  32'h1,         32'h1F,        32'h8000_0000, 1);
        runCheck("xor",      OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
        runCheck("or",       OP_OR,   32'hF0F0_F0F0, 32'h0F00_0000, 32'hFFF0_F0F0, 1);
        runCheck("and",      OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
        runCheck("rsv",      OP_RSV0, 32'h5,         32'h6,         32'h0,         1);

        // Long ops
        runCheck("mul",       OP_MUL,   32'h1_0000,    32'h1_0000,    32'h0,         33);
        runCheck("mulhu",     OP_MULHU, 32'h1_0000,    32'h1_0000,    32'h1,         33);
        runCheck("mul_max",   OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         33);
        runCheck("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        runCheck("mul_small", OP_MUL,   32'h3,         32'h5,         32'hF,         33);
        runCheck("divu",      OP_DIVU,  32'd100,       32'd7,         32'd14,        33);
        runCheck("remu",      OP_REMU,  32'd100,       32'd7,         32'd2,         33);
        runCheck("divu_zero", OP_DIVU,  32'h1234,      32'h0,         32'hFFFF_FFFF, 33);
        runCheck("remu_zero", OP_REMU,  32'h1234,      32'h0,         32'h1234,      33);
        runCheck("divu_big",  OP_DIVU,  32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 33);

        // Backpressure: result must hold while the consumer stalls
        runCheck("bp_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.a = 32'h1111_0000 + i;
            checkOutput($sformatf("bp_hold_result_%0d", i), bus.result, 32'd5);
            checkOutput($sformatf("bp_hold_valid_%0d", i), {31'b0, bus.out_valid}, 32'd1);
            checkOutput($sformatf("bp_in_ready_%0d", i), {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("b2b_in_ready", {31'b0, bus.in_ready}, 32'd1);
        runCheck("b2b_add", OP_ADD, 32'd1, 32'd1, 32'd2, 1);

        // Flush after MUL iteration 3, with a handshake attempt in the flush cycle
        bus.op       = OP_MUL;
        bus.a        = 32'd3;
        bus.b        = 32'd5;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("busy_in_ready", {31'b0, bus.in_ready}, 32'd0);
        checkOutput("busy_out_valid", {31'b0, bus.out_valid}, 32'd0);
        flush        = 1'b1;
        bus.op       = OP_ADD;
        bus.a        = 32'd7;
        bus.b        = 32'd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        checkOutput("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) pulses++;
        end
        checkOutput("flush_no_valid", pulses, 32'd0);
        runCheck("post_flush_add", OP_ADD, 32'd4, 32'd4, 32'd8, 1);

        // Reset during DIVU iteration 10
        bus.op       = OP_DIVU;
        bus.a        = 32'd100;
        bus.b        = 32'd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("midrst_result", bus.result, 32'd0);
        checkOutput("midrst_zero", {31'b0, bus.zero}, 32'd1);
        @(negedge clk) reset = 1'b0;
        #1;
        checkOutput("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        runCheck("post_rst_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
